// File: rtl/event_arbiter_if.sv
// Requester, log-sink and status signals of the event arbiter.
// The arbiter uses the slave view; the requesters and sink use the master view.
interface event_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int PAYLOAD_W = 16,
  parameter int TIME_W    = 32
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [3*NUM_REQ-1:0]         req_level;
  logic [PAYLOAD_W*NUM_REQ-1:0] req_payload;
  logic [NUM_REQ-1:0]           req_done;

  logic                         out_valid;
  logic                         out_ready;
  logic [SRC_W-1:0]             out_src;
  logic [2:0]                   out_level;
  logic [PAYLOAD_W-1:0]         out_payload;
  logic [TIME_W-1:0]            out_time;

  logic [15:0]                  err_count;
  logic                         halt;

  modport master (
    output req_valid, req_level, req_payload, req_done, out_ready,
    input  req_ready, out_valid, out_src, out_level, out_payload, out_time,
           err_count, halt
  );

  modport slave (
    input  req_valid, req_level, req_payload, req_done, out_ready,
    output req_ready, out_valid, out_src, out_level, out_payload, out_time,
           err_count, halt
  );
endinterface

// File: rtl/event_arbiter.sv
// Round-robin event arbiter feeding a single-entry timestamped log register.
// state   | meaning
// RUN     | arbitrating requesters into the log register
// DRAIN   | FATAL granted; no more grants, waiting for the sink to take it
// HALTED  | terminal until reset; halt=1, no grants
module event_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PAYLOAD_W = 16,
  parameter int TIME_W    = 32
) (
  input logic           clk,
  input logic           rst_n,
  event_arbiter_if.slave bus
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0] LVL_INFO  = 3'd2;
  localparam logic [2:0] LVL_ERROR = 3'd4;
  localparam logic [2:0] LVL_FATAL = 3'd5;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t               state;
  logic [SRC_W-1:0]     ptr;
  logic [TIME_W-1:0]    timestamp;

  logic [2:0]           lvl_arr [NUM_REQ];
  logic [PAYLOAD_W-1:0] pay_arr [NUM_REQ];

  logic                 gnt_found;
  logic [SRC_W-1:0]     gnt_idx;
  logic [SRC_W:0]       cand;
  logic [SRC_W-1:0]     cand_idx;
  logic [SRC_W-1:0]     ptr_next;
  logic [2:0]           gnt_level;
  logic                 reg_free;
  logic                 accept;
  logic                 grant;
  logic                 all_done;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign lvl_arr[g] = bus.req_level[3*g +: 3];
    assign pay_arr[g] = bus.req_payload[PAYLOAD_W*g +: PAYLOAD_W];
  end

  assign accept   = bus.out_valid & bus.out_ready;
  assign reg_free = ~bus.out_valid | bus.out_ready;
  assign all_done = (&bus.req_done) & ~(|bus.req_valid);

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (SRC_W+1)'(k);
      if (cand >= (SRC_W+1)'(NUM_REQ)) begin
        cand = cand - (SRC_W+1)'(NUM_REQ);
      end
      cand_idx = cand[SRC_W-1:0];
      if (!gnt_found && bus.req_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  // rst_n gates the grant so req_ready is zero the moment reset asserts.
  assign grant = rst_n & (state == ST_RUN) & reg_free & gnt_found;

  always_comb begin
    bus.req_ready = '0;
    if (grant) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  // Undefined tones 6 and 7 are logged as INFO.
  always_comb begin
    gnt_level = lvl_arr[gnt_idx];
    if (gnt_level > LVL_FATAL) begin
      gnt_level = LVL_INFO;
    end
  end

  assign ptr_next = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_RUN;
      ptr             <= '0;
      timestamp       <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_src     <= '0;
      bus.out_level   <= '0;
      bus.out_payload <= '0;
      bus.out_time    <= '0;
      bus.err_count   <= '0;
      bus.halt        <= 1'b0;
    end else begin
      timestamp <= timestamp + 1'b1;

      if (accept) begin
        bus.out_valid <= 1'b0;
        if (bus.out_level >= LVL_ERROR && bus.err_count != 16'hFFFF) begin
          bus.err_count <= bus.err_count + 16'd1;
        end
      end

      // A grant implies the register is free, so it overrides the clear above.
      if (grant) begin
        bus.out_valid   <= 1'b1;
        bus.out_src     <= gnt_idx;
        bus.out_level   <= gnt_level;
        bus.out_payload <= pay_arr[gnt_idx];
        bus.out_time    <= timestamp;
        ptr             <= ptr_next;
      end

      case (state)
        ST_RUN: begin
          if (grant && gnt_level == LVL_FATAL) begin
            state <= ST_DRAIN;
          end else if (all_done && reg_free) begin
            state    <= ST_HALTED;
            bus.halt <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // Only the FATAL record can be in the register here.
          if (accept) begin
            state    <= ST_HALTED;
            bus.halt <= 1'b1;
          end
        end
        ST_HALTED: begin
          bus.halt <= 1'b1;
        end
        default: begin
          state <= ST_HALTED;
          bus.halt <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_event_arbiter.sv
// Directed bench for event_arbiter: grant order, back-pressure, FATAL drain,
// done-halt, reset discard, timestamp wrap and err_count saturation.
module tb_event_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int PAYLOAD_W = 16;
  localparam int TIME_W    = 4;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  event_arbiter_if #(.NUM_REQ(NUM_REQ), .PAYLOAD_W(PAYLOAD_W), .TIME_W(TIME_W)) bus ();

  event_arbiter #(.NUM_REQ(NUM_REQ), .PAYLOAD_W(PAYLOAD_W), .TIME_W(TIME_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] lvl, input logic [15:0] pl);
    bus.req_level[3*i +: 3]    = lvl;
    bus.req_payload[16*i +: 16] = pl;
  endtask

  initial begin
    logic [2:0] exp_lvl [4];
    exp_lvl = '{3'd0, 3'd1, 3'd2, 3'd3};
    n_assert = 0;
    n_fail   = 0;

    // Reset with requests pending: nothing may be granted.
    rst_n           = 1'b0;
    bus.req_valid   = 4'hF;
    bus.req_level   = '0;
    bus.req_payload = '0;
    bus.req_done    = '0;
    bus.out_ready   = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_time",  32'(bus.out_time), 32'h0);
    chk("rst_err",   32'(bus.err_count), 32'h0);
    chk("rst_halt",  32'(bus.halt), 32'h0);

    // Round robin with all four valid; requester 2 uses tone 7 -> INFO.
    rst_n = 1'b1;
    set_req(0, 3'd0, 16'hA000);
    set_req(1, 3'd1, 16'hA001);
    set_req(2, 3'd7, 16'hA002);
    set_req(3, 3'd3, 16'hA003);
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    #1;
    chk("rr_first_ready", 32'(bus.req_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_valid",   32'(bus.out_valid), 32'h1);
      chk("rr_src",     32'(bus.out_src), 32'(k % 4));
      chk("rr_time",    32'(bus.out_time), 32'(k));
      chk("rr_level",   32'(bus.out_level), 32'(exp_lvl[k % 4]));
      chk("rr_payload", 32'(bus.out_payload), 32'hA000 + 32'(k % 4));
      if (k < 7) begin
        chk("rr_ready", 32'(bus.req_ready), 32'h1 << ((k + 1) % 4));
      end else begin
        bus.req_valid = 4'h0;
      end
    end
    tick();  // cycle 9
    chk("rr_idle_valid", 32'(bus.out_valid), 32'h0);
    chk("rr_err", 32'(bus.err_count), 32'h0);

    // ERROR record held under back-pressure for five cycles.
    bus.out_ready = 1'b0;
    set_req(2, 3'd4, 16'h2222);
    set_req(0, 3'd0, 16'h0AAA);
    bus.req_valid = 4'b0100;
    #1;
    chk("bp_ready", 32'(bus.req_ready), 32'b0100);
    tick();  // cycle 10
    bus.req_valid = 4'b0101;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      chk("bp_hold_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_hold_src",   32'(bus.out_src), 32'd2);
      chk("bp_hold_level", 32'(bus.out_level), 32'd4);
      chk("bp_hold_time",  32'(bus.out_time), 32'd9);
      chk("bp_hold_pay",   32'(bus.out_payload), 32'h2222);
      chk("bp_no_grant",   32'(bus.req_ready), 32'h0);
    end
    // cycle 14: sink accepts, next grant searches from 3 and lands on 0
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0001;
    #1;
    chk("bp_next_ready", 32'(bus.req_ready), 32'b0001);
    tick();  // cycle 15
    chk("bp_next_src",  32'(bus.out_src), 32'd0);
    chk("bp_next_time", 32'(bus.out_time), 32'd14);
    chk("bp_err_one",   32'(bus.err_count), 32'd1);
    bus.req_valid = 4'h0;
    tick();  // cycle 16
    chk("bp_idle", 32'(bus.out_valid), 32'h0);
    chk("bp_err_still_one", 32'(bus.err_count), 32'd1);

    // FATAL from requester 1 while 0 and 3 are also valid.
    set_req(1, 3'd5, 16'hF1F1);
    set_req(0, 3'd2, 16'h0B0B);
    set_req(3, 3'd2, 16'h3B3B);
    bus.req_valid = 4'b1011;
    bus.out_ready = 1'b0;
    #1;
    chk("fatal_ready", 32'(bus.req_ready), 32'b0010);
    tick();  // cycle 17
    chk("fatal_src",   32'(bus.out_src), 32'd1);
    chk("fatal_level", 32'(bus.out_level), 32'd5);
    chk("fatal_time_wrap", 32'(bus.out_time), 32'd0);
    chk("fatal_pay",   32'(bus.out_payload), 32'hF1F1);
    bus.out_ready = 1'b1;
    #1;
    chk("drain_no_grant", 32'(bus.req_ready), 32'h0);
    chk("drain_halt", 32'(bus.halt), 32'h0);
    tick();  // cycle 18
    chk("fatal_halt", 32'(bus.halt), 32'h1);
    chk("fatal_out_valid", 32'(bus.out_valid), 32'h0);
    chk("fatal_err", 32'(bus.err_count), 32'd2);
    chk("halted_no_grant", 32'(bus.req_ready), 32'h0);

    // Reset clears halt and err_count immediately.
    rst_n = 1'b0;
    #1;
    chk("rst2_halt", 32'(bus.halt), 32'h0);
    chk("rst2_err",  32'(bus.err_count), 32'h0);
    tick();
    rst_n = 1'b1;
    set_req(2, 3'd2, 16'h3333);
    bus.req_valid = 4'b0100;
    bus.out_ready = 1'b0;
    #1;
    chk("rst2_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    chk("rst2_rec_valid", 32'(bus.out_valid), 32'h1);
    chk("rst2_rec_time",  32'(bus.out_time), 32'd0);

    // Reset mid-transfer discards the held record.
    rst_n = 1'b0;
    #1;
    chk("rst3_valid", 32'(bus.out_valid), 32'h0);
    chk("rst3_src",   32'(bus.out_src), 32'h0);
    chk("rst3_pay",   32'(bus.out_payload), 32'h0);
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'hF;
    bus.out_ready = 1'b1;
    #1;
    chk("rst3_ptr_zero", 32'(bus.req_ready), 32'b0001);
    tick();
    chk("rst3_src0",  32'(bus.out_src), 32'd0);
    chk("rst3_time0", 32'(bus.out_time), 32'd0);

    // Done-with-valid is still arbitrated; halt follows once valid drops.
    bus.req_done  = 4'hF;
    bus.req_valid = 4'b0010;
    #1;
    chk("done_valid_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    chk("done_rec_src", 32'(bus.out_src), 32'd1);
    chk("done_no_halt", 32'(bus.halt), 32'h0);
    bus.req_valid = 4'h0;
    tick();
    chk("done_halt", 32'(bus.halt), 32'h1);
    chk("done_out_valid", 32'(bus.out_valid), 32'h0);
    bus.req_valid = 4'hF;
    bus.req_done  = 4'h0;
    #1;
    chk("done_halt_no_grant", 32'(bus.req_ready), 32'h0);
    tick();
    bus.req_valid = 4'h5;
    tick();
    chk("done_halt_sticky", 32'(bus.halt), 32'h1);

    // Stream of ERROR records: timestamp wrap and err_count saturation.
    rst_n = 1'b0;
    bus.req_valid = 4'h0;
    tick();
    rst_n = 1'b1;
    set_req(0, 3'd4, 16'h00EE);
    bus.req_valid = 4'b0001;
    bus.out_ready = 1'b1;
    tick();                 // cycle 1
    repeat (15) tick();     // cycle 16
    chk("wrap_t15", 32'(bus.out_time), 32'd15);
    tick();                 // cycle 17
    chk("wrap_t0", 32'(bus.out_time), 32'd0);
    repeat (83) tick();     // cycle 100
    chk("err_mid", 32'(bus.err_count), 32'd99);
    repeat (65436) tick();  // cycle 65536
    chk("err_sat", 32'(bus.err_count), 32'hFFFF);
    repeat (4) tick();      // cycle 65540
    chk("err_sat_hold", 32'(bus.err_count), 32'hFFFF);
    bus.req_valid = 4'h0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/event_arbiter.md
EVENT_ARBITER -- requirements
Module: event_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of event requesters (2..16).
REQ-002 Parameter PAYLOAD_W, default 16, per-event payload width.
REQ-003 Parameter TIME_W, default 32, timestamp width.
REQ-004 One clock; reset is asynchronous and active-low. Ports clk and rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  NUM_REQ  requester i has an event pending.
REQ-008 req_ready  out  NUM_REQ  one-hot grant; event i is accepted this cycle.
REQ-009 req_level  in  3*NUM_REQ  tone per requester: 0 TRACE, 1 DEBUG, 2 INFO, 3 WARN, 4 ERROR, 5 FATAL.
REQ-010 req_payload  in  PAYLOAD_W*NUM_REQ  event payload per requester.
REQ-011 req_done  in  NUM_REQ  requester i has no further events (level, not pulse).
REQ-012 out_valid  out  1  log record is available.
REQ-013 out_ready  in  1  log sink accepts the record.
REQ-014 out_src  out  clog2(NUM_REQ)  index of the originating requester.
REQ-015 out_level  out  3  record tone.
REQ-016 out_payload  out  PAYLOAD_W  record payload.
REQ-017 out_time  out  TIME_W  timestamp of the grant cycle.
REQ-018 err_count  out  16  count of ERROR/FATAL records accepted by the sink.
REQ-019 halt  out  1  simulation is complete or fatal; sticky until reset.

Function
REQ-020 Timestamp counter increments every cycle from 0 after reset and wraps modulo 2^TIME_W.
REQ-021 The single-entry output register is "free" when out_valid=0 or (out_valid & out_ready).
REQ-022 In state RUN with the register free, the block grants the first i with req_valid[i]=1, searching i = ptr, ptr+1, ... modulo NUM_REQ; req_ready is combinational and one-hot.
REQ-023 When no requester is valid, or the register is not free, or the state is not RUN, req_ready is all zeros.
REQ-024 On a grant, the record loads on the next rising edge: out_valid=1, fields from requester i, out_time=timestamp of the grant cycle. Latency is 1 cycle.
REQ-025 On a grant, ptr becomes (i+1) mod NUM_REQ; ptr is unchanged without a grant.
REQ-026 Sustained throughput is 1 record per cycle while out_ready=1.
REQ-027 While out_valid=1 and out_ready=0, all out_* fields hold stable.
REQ-028 req_level values 6 and 7 are recorded as INFO (2).
REQ-029 err_count increments on out_valid & out_ready when out_level is 4 or 5, and saturates at 0xFFFF.
REQ-030 States are RUN, DRAIN and HALTED.
REQ-031 RUN->DRAIN on granting a FATAL event; no further grants occur.
REQ-032 RUN->HALTED when req_done is all ones, req_valid is all zeros, and the register is empty (out_valid=0, or accepted this cycle), all evaluated in the same cycle.
REQ-033 DRAIN->HALTED when the FATAL record is accepted by the sink.
REQ-034 HALTED is terminal until reset: halt=1 and req_ready=0.
REQ-035 If req_valid[i] and req_done[i] are both high, the event is still arbitrated; done counts only once valid drops.

Reset
REQ-036 While rst_n=0, immediately and asynchronously: out_valid=0, out_src=0, out_level=0, out_payload=0, out_time=0, err_count=0, halt=0, req_ready=0, ptr=0, timestamp=0, state=RUN.
REQ-037 Reset asserted mid-transfer discards the held record; no partial record reappears after release.
REQ-038 The first possible grant is in the first cycle after rst_n rises (timestamp 0).

Verification
REQ-039 Requesters 0..3 all valid continuously, out_ready=1 -> grant order 0,1,2,3,0,... with out_time increasing by 1 per record.
REQ-040 Requester 2 valid with level 4, out_ready held 0 for 5 cycles -> record is stable for 5 cycles; err_count=1 after acceptance; the next grant occurs only after acceptance.
REQ-041 Requester 1 issues FATAL while 0 and 3 are valid -> no grants after FATAL; halt=1 the cycle after FATAL is accepted; err_count increments by 1.
REQ-042 All req_done=1, no valid, register empty -> halt=1 next cycle; stays 1 while inputs toggle.
REQ-043 300 000 ERROR records -> err_count=0xFFFF; with TIME_W=4, out_time wraps 15->0.
REQ-044 rst_n pulsed low while out_valid=1 -> out_valid=0 immediately; ptr restarts at 0.
